// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
// Round-robin arbiter that shares one I2C master engine between several
// register-transaction requesters. It latches the winning requester's
// transaction into the master command port and holds m_enable for two cycles.
// It then waits for the master to report done, or for the timeout to expire,
// and returns the read data and error status to the winning requester only.
//
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   req                 per-requester request level
//   req_chip_addr       packed 7-bit chip addresses, slice i = [7i+6:7i]
//   req_reg_addr        packed 8-bit register addresses
//   req_value           packed 8-bit write data
//   req_is_read         per-requester read(1)/write(0)
//   ack                 one-cycle completion pulse to the granted requester
//   rsp_data            read data, valid with ack, held until the next response
//   rsp_error           NACK or timeout, valid with ack
//   busy                high while a transaction is in flight
//   timeout             sticky timeout flag, cleared only by reset
//   m_chip_addr, m_reg_addr, m_value, m_is_read, m_enable   master command
//   m_data, m_done, m_ack_error                             master status
module i2c_bus_arbiter #(
  parameter int unsigned      N_REQ          = 3,
  parameter int unsigned      CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd4_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_chip_addr,
  input  logic [8*N_REQ-1:0] req_reg_addr,
  input  logic [8*N_REQ-1:0] req_value,
  input  logic [N_REQ-1:0]   req_is_read,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         rsp_data,
  output logic               rsp_error,
  output logic               busy,
  output logic               timeout,
  output logic [6:0]         m_chip_addr,
  output logic [7:0]         m_reg_addr,
  output logic [7:0]         m_value,
  output logic               m_is_read,
  output logic               m_enable,
  input  logic [7:0]         m_data,
  input  logic               m_done,
  input  logic               m_ack_error
);

  localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT_CYCLES - CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT_DONE,
    RESP
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [6:0]       chip_nxt;
  logic [7:0]       reg_nxt;
  logic [7:0]       value_nxt;
  logic             is_read_nxt;
  logic [7:0]       rsp_data_nxt;
  logic             rsp_error_nxt;
  logic             timeout_nxt;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [6:0]       sel_chip;
  logic [7:0]       sel_reg;
  logic [7:0]       sel_value;
  logic             sel_is_read;

  // (base + step) mod N_REQ for step in 1..N_REQ, without a divider.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int unsigned      step);
    int unsigned sum;
    sum = 32'(base) + step;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IDX_W'(sum);
  endfunction

  // Scan starts one past the last grant, so the most recently served
  // requester is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!win_found && req[rr_index(last_grant, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(last_grant, k);
      end
    end
  end

  always_comb begin
    sel_chip    = '0;
    sel_reg     = '0;
    sel_value   = '0;
    sel_is_read = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_chip    = req_chip_addr[7*i +: 7];
        sel_reg     = req_reg_addr[8*i +: 8];
        sel_value   = req_value[8*i +: 8];
        sel_is_read = req_is_read[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= LAST_IDX;
      cnt         <= '0;
      m_chip_addr <= '0;
      m_reg_addr  <= '0;
      m_value     <= '0;
      m_is_read   <= 1'b0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_grant_nxt;
      cnt         <= cnt_nxt;
      m_chip_addr <= chip_nxt;
      m_reg_addr  <= reg_nxt;
      m_value     <= value_nxt;
      m_is_read   <= is_read_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_error   <= rsp_error_nxt;
      timeout     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    chip_nxt       = m_chip_addr;
    reg_nxt        = m_reg_addr;
    value_nxt      = m_value;
    is_read_nxt    = m_is_read;
    rsp_data_nxt   = rsp_data;
    rsp_error_nxt  = rsp_error;
    timeout_nxt    = timeout;

    case (state)
      IDLE: begin
        // A new transaction is only started when the master reports idle.
        if (win_found && m_done) begin
          grant_nxt   = win_idx;
          chip_nxt    = sel_chip;
          reg_nxt     = sel_reg;
          value_nxt   = sel_value;
          is_read_nxt = sel_is_read;
          cnt_nxt     = '0;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = cnt + CNT_W'(1);
        state_nxt = HOLD;
      end
      HOLD: begin
        cnt_nxt   = cnt + CNT_W'(1);
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_nxt = cnt + CNT_W'(1);
        // Master completion takes priority over a timeout in the same cycle.
        if (m_done) begin
          rsp_data_nxt  = m_data;
          rsp_error_nxt = m_ack_error;
          state_nxt     = RESP;
        end else if (cnt == TMO_LAST) begin
          rsp_data_nxt  = 8'h00;
          rsp_error_nxt = 1'b1;
          timeout_nxt   = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        last_grant_nxt = grant;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      ack[i] = (state == RESP) && (grant == IDX_W'(i));
    end
  end

  assign m_enable = (state == ISSUE) || (state == HOLD);
  assign busy     = (state == ISSUE) || (state == HOLD) || (state == WAIT_DONE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter with three requesters and a short timeout.
// The stimulus thread pushes the expected transaction results into a
// scoreboard queue. The monitor thread pops and compares an entry whenever
// ack is presented. The master engine is a behavioural model that drops done
// when it sees enable, stays busy for a programmable number of cycles (or
// hangs), and then returns data and an ACK status.
module tb_i2c_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [20:0] req_chip_addr;
  logic [23:0] req_reg_addr;
  logic [23:0] req_value;
  logic [2:0]  req_is_read;
  logic [2:0]  ack;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        busy;
  logic        timeout;
  logic [6:0]  m_chip_addr;
  logic [7:0]  m_reg_addr;
  logic [7:0]  m_value;
  logic        m_is_read;
  logic        m_enable;
  logic [7:0]  m_data;
  logic        m_done;
  logic        m_ack_error;

  i2c_bus_arbiter #(
    .N_REQ         (3),
    .CNT_W         (24),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_chip_addr(req_chip_addr),
    .req_reg_addr (req_reg_addr),
    .req_value    (req_value),
    .req_is_read  (req_is_read),
    .ack          (ack),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .busy         (busy),
    .timeout      (timeout),
    .m_chip_addr  (m_chip_addr),
    .m_reg_addr   (m_reg_addr),
    .m_value      (m_value),
    .m_is_read    (m_is_read),
    .m_enable     (m_enable),
    .m_data       (m_data),
    .m_done       (m_done),
    .m_ack_error  (m_ack_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] ack;
    logic [6:0] chip;
    logic [7:0] rg;
    logic [7:0] val;
    logic       rd;
    logic [7:0] data;
    logic       err;
    logic       tmo;
    int         lat;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  exp_t  sb[$];
  dchk_t dq[$];

  int checks = 0;
  int errors = 0;

  int         target [3];
  int         issued [3];
  int         mst_len;
  logic       mst_hang;
  logic [7:0] mst_data;
  logic       mst_err;

  function automatic string dname(input int id);
    case (id)
      0:       return "rst_ack";
      1:       return "rst_busy";
      2:       return "rst_timeout";
      3:       return "rst_m_enable";
      4:       return "rst_rsp_data";
      5:       return "rst_rsp_error";
      6:       return "rst_m_chip_addr";
      7:       return "rst_m_reg_addr";
      8:       return "rst_m_value";
      9:       return "rst_m_is_read";
      10:      return "abort_m_enable";
      11:      return "abort_busy";
      12:      return "abort_ack";
      13:      return "abort_timeout";
      default: return "direct";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Requesters: raise req while more transactions are wanted, drop it on ack.
  initial begin
    req = '0;
    for (int i = 0; i < 3; i++) issued[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        req = '0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (ack[i]) begin
            req[i] = 1'b0;
          end else if (!req[i] && issued[i] < target[i]) begin
            req[i] = 1'b1;
            issued[i] = issued[i] + 1;
          end
        end
      end
    end
  end

  // Master engine model.
  initial begin
    automatic bit active = 1'b0;
    automatic int mcnt   = 0;
    m_done      = 1'b1;
    m_data      = 8'h00;
    m_ack_error = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active = 1'b0;
        m_done = 1'b1;
      end else if (!active) begin
        if (m_enable) begin
          active      = 1'b1;
          m_done      = 1'b0;
          mcnt        = mst_len;
          m_data      = 8'hEE;
          m_ack_error = 1'b0;
        end
      end else if (!mst_hang) begin
        if (mcnt <= 1) begin
          active      = 1'b0;
          m_done      = 1'b1;
          m_data      = mst_data;
          m_ack_error = mst_err;
        end else begin
          mcnt = mcnt - 1;
        end
      end
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    automatic int   cyc     = 0;
    automatic int   t_grant = 0;
    automatic int   en_cnt  = 0;
    automatic int   wd      = 0;
    automatic logic busy_q  = 1'b0;
    exp_t  e;
    dchk_t d;
    forever begin
      @(negedge clk);
      cyc++;
      while (dq.size() > 0) begin
        d = dq.pop_front();
        chk(dname(d.id), d.act, d.exp);
      end
      if (!reset) begin
        en_cnt = 0;
        busy_q = 1'b0;
        wd     = 0;
      end else begin
        if (m_enable) en_cnt++;
        if (busy && !busy_q) t_grant = cyc;
        busy_q = busy;
        if (ack != '0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack actual=%b expected=none", ack);
          end else begin
            e = sb.pop_front();
            chk("ack",           32'(ack),          32'(e.ack));
            chk("m_chip_addr",   32'(m_chip_addr),  32'(e.chip));
            chk("m_reg_addr",    32'(m_reg_addr),   32'(e.rg));
            chk("m_value",       32'(m_value),      32'(e.val));
            chk("m_is_read",     32'(m_is_read),    32'(e.rd));
            chk("enable_cycles", 32'(en_cnt),       32'd2);
            chk("rsp_data",      32'(rsp_data),     32'(e.data));
            chk("rsp_error",     32'(rsp_error),    32'(e.err));
            chk("timeout",       32'(timeout),      32'(e.tmo));
            chk("latency",       32'(cyc - t_grant), 32'(e.lat));
          end
          en_cnt = 0;
          wd     = 0;
        end else if (sb.size() > 0) begin
          wd++;
          if (wd > 400) begin
            checks++;
            errors++;
            $display("FAIL ack_wait actual=no_ack expected=ack %b", sb[0].ack);
            void'(sb.pop_front());
            wd = 0;
          end
        end else begin
          wd = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic set_fields(input int i, input logic [6:0] c, input logic [7:0] r,
                            input logic [7:0] v, input logic rd);
    req_chip_addr[7*i +: 7] = c;
    req_reg_addr[8*i +: 8]  = r;
    req_value[8*i +: 8]     = v;
    req_is_read[i]          = rd;
  endtask

  task automatic expect_txn(input int i, input logic [6:0] c, input logic [7:0] r,
                            input logic [7:0] v, input logic rd, input logic [7:0] data,
                            input logic err, input logic tmo, input int lat);
    exp_t e;
    e.ack  = 3'b001 << i;
    e.chip = c;
    e.rg   = r;
    e.val  = v;
    e.rd   = rd;
    e.data = data;
    e.err  = err;
    e.tmo  = tmo;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic dpush(input int id, input logic [31:0] act, input logic [31:0] exp);
    dchk_t d;
    d.id  = id;
    d.act = act;
    d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic wait_drain();
    automatic int g = 0;
    while ((sb.size() != 0 || busy) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
  endtask

  // Stimulus. Expected latency is counted from the first busy cycle to the
  // ack cycle: busy-length + 1 for a normal master, 100 for a timeout.
  initial begin
    reset         = 1'b0;
    req_chip_addr = '0;
    req_reg_addr  = '0;
    req_value     = '0;
    req_is_read   = '0;
    for (int i = 0; i < 3; i++) target[i] = 0;
    mst_len  = 20;
    mst_hang = 1'b0;
    mst_data = 8'h00;
    mst_err  = 1'b0;

    repeat (3) @(negedge clk);
    dpush(0, 32'(ack),         32'd0);
    dpush(1, 32'(busy),        32'd0);
    dpush(2, 32'(timeout),     32'd0);
    dpush(3, 32'(m_enable),    32'd0);
    dpush(4, 32'(rsp_data),    32'd0);
    dpush(5, 32'(rsp_error),   32'd0);
    dpush(6, 32'(m_chip_addr), 32'd0);
    dpush(7, 32'(m_reg_addr),  32'd0);
    dpush(8, 32'(m_value),     32'd0);
    dpush(9, 32'(m_is_read),   32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single write from requester 0, master busy for 20 cycles.
    set_fields(0, 7'h38, 8'h08, 8'hBF, 1'b0);
    mst_len = 20; mst_data = 8'h00; mst_err = 1'b0;
    expect_txn(0, 7'h38, 8'h08, 8'hBF, 1'b0, 8'h00, 1'b0, 1'b0, 21);
    target[0] = target[0] + 1;
    wait_drain();

    // Read from requester 1 returning 8'h06.
    set_fields(1, 7'h50, 8'h09, 8'h00, 1'b1);
    mst_len = 5; mst_data = 8'h06; mst_err = 1'b0;
    expect_txn(1, 7'h50, 8'h09, 8'h00, 1'b1, 8'h06, 1'b0, 1'b0, 6);
    target[1] = target[1] + 1;
    wait_drain();

    // NACK on requester 2: error reported, timeout flag untouched.
    set_fields(2, 7'h39, 8'h33, 8'h44, 1'b0);
    mst_len = 4; mst_data = 8'h77; mst_err = 1'b1;
    expect_txn(2, 7'h39, 8'h33, 8'h44, 1'b0, 8'h77, 1'b1, 1'b0, 5);
    target[2] = target[2] + 1;
    wait_drain();

    // Contention: all three held, each re-raised once after its ack.
    set_fields(0, 7'h11, 8'h20, 8'h30, 1'b0);
    set_fields(1, 7'h12, 8'h21, 8'h31, 1'b1);
    set_fields(2, 7'h13, 8'h22, 8'h32, 1'b0);
    mst_len = 3; mst_data = 8'h5A; mst_err = 1'b0;
    for (int r = 0; r < 2; r++) begin
      expect_txn(0, 7'h11, 8'h20, 8'h30, 1'b0, 8'h5A, 1'b0, 1'b0, 4);
      expect_txn(1, 7'h12, 8'h21, 8'h31, 1'b1, 8'h5A, 1'b0, 1'b0, 4);
      expect_txn(2, 7'h13, 8'h22, 8'h32, 1'b0, 8'h5A, 1'b0, 1'b0, 4);
    end
    for (int i = 0; i < 3; i++) target[i] = target[i] + 2;
    wait_drain();

    // Timeout on requester 2: master never returns done.
    set_fields(2, 7'h60, 8'h7E, 8'h01, 1'b1);
    mst_len = 5; mst_hang = 1'b1; mst_data = 8'hC3; mst_err = 1'b0;
    expect_txn(2, 7'h60, 8'h7E, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 100);
    target[2] = target[2] + 1;
    wait_drain();
    mst_hang = 1'b0;

    // Timeout flag stays set across a later good transaction.
    set_fields(0, 7'h1C, 8'h05, 8'h3C, 1'b0);
    mst_len = 2; mst_data = 8'h3C; mst_err = 1'b0;
    expect_txn(0, 7'h1C, 8'h05, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b1, 3);
    target[0] = target[0] + 1;
    wait_drain();

    // Reset in the middle of a hung transaction from requester 1.
    set_fields(1, 7'h50, 8'h0A, 8'h00, 1'b1);
    mst_len = 5; mst_hang = 1'b1;
    target[1] = target[1] + 1;
    begin
      automatic int g = 0;
      while (!busy && g < 50) begin
        @(negedge clk);
        g++;
      end
    end
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dpush(10, 32'(m_enable), 32'd0);
    dpush(11, 32'(busy),     32'd0);
    dpush(12, 32'(ack),      32'd0);
    dpush(13, 32'(timeout),  32'd0);
    repeat (2) @(negedge clk);
    mst_hang = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // After reset requester 0 wins first even though 1 was served more recently.
    set_fields(0, 7'h2A, 8'h01, 8'h02, 1'b0);
    mst_len = 3; mst_data = 8'h9D; mst_err = 1'b0;
    expect_txn(0, 7'h2A, 8'h01, 8'h02, 1'b0, 8'h9D, 1'b0, 1'b0, 4);
    expect_txn(1, 7'h50, 8'h0A, 8'h00, 1'b1, 8'h9D, 1'b0, 1'b0, 4);
    target[0] = target[0] + 1;
    target[1] = target[1] + 1;
    wait_drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
